// File: rtl/wbu_pkg.sv
// Shared pipeline definitions used by the write-back stage and its interface.
package wbu_pkg;
  localparam int         XLEN     = 64;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_A0   = 5'd10;

  typedef enum logic {WB_RUN, WB_HALT} wb_state_e;
endpackage

// File: rtl/wbu_if.sv
// Memory-stage inputs, decode read ports and commit/halt outputs of the write-back stage.
interface wbu_if #(parameter int XLEN = wbu_pkg::XLEN);
  logic            instr_valid;
  logic            mmu_valid;
  logic            mmu_wb_en;
  logic [4:0]      mmu_index_rd;
  logic [XLEN-1:0] mmu_wb_data;
  logic            mmu_ebreak_en;
  logic [XLEN-1:0] mmu_pc;
  logic [31:0]     mmu_instr;
  logic [4:0]      idu_index_rs1;
  logic [4:0]      idu_index_rs2;
  logic [XLEN-1:0] idu_data_rs1;
  logic [XLEN-1:0] idu_data_rs2;
  logic            wbu_valid;
  logic [XLEN-1:0] wbu_pc;
  logic [31:0]     wbu_instr;
  logic            halt;
  logic [XLEN-1:0] halt_code;
  logic [XLEN-1:0] cycle_cnt;
  logic [XLEN-1:0] retire_cnt;

  modport slave (
    input  instr_valid, mmu_valid, mmu_wb_en, mmu_index_rd, mmu_wb_data,
           mmu_ebreak_en, mmu_pc, mmu_instr, idu_index_rs1, idu_index_rs2,
    output idu_data_rs1, idu_data_rs2, wbu_valid, wbu_pc, wbu_instr,
           halt, halt_code, cycle_cnt, retire_cnt
  );

  modport master (
    output instr_valid, mmu_valid, mmu_wb_en, mmu_index_rd, mmu_wb_data,
           mmu_ebreak_en, mmu_pc, mmu_instr, idu_index_rs1, idu_index_rs2,
    input  idu_data_rs1, idu_data_rs2, wbu_valid, wbu_pc, wbu_instr,
           halt, halt_code, cycle_cnt, retire_cnt
  );
endinterface

// File: rtl/wbu_regfile.sv
// 31x XLEN integer register file: one write port, three bypassed read ports, x0 hardwired to 0.
module regfile
  import wbu_pkg::*;
#(
  parameter int         XLEN     = wbu_pkg::XLEN,
  parameter logic [4:0] EXIT_REG = REG_A0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic [XLEN-1:0] exit_data
);
  logic [31:1][XLEN-1:0] regs;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) regs <= '0;
    else if (we) begin
      for (int i = 1; i < 32; i++)
        if (waddr == 5'(i)) regs[i] <= wdata;
    end
  end

  // A write in flight is forwarded so decode sees it in the same cycle.
  function automatic logic [XLEN-1:0] rd_port(input logic [4:0] idx);
    if (idx == REG_ZERO)                          return '0;
    else if (we && waddr != REG_ZERO && idx == waddr) return wdata;
    else                                          return regs[idx];
  endfunction

  assign rd1       = rd_port(rs1);
  assign rd2       = rd_port(rs2);
  assign exit_data = rd_port(EXIT_REG);
endmodule

// File: rtl/wbu.sv
// Write-back stage: register file update, commit reporting, ebreak halt and perf counters.
module wbu
  import wbu_pkg::*;
#(
  parameter int         XLEN     = wbu_pkg::XLEN,
  parameter logic [4:0] EXIT_REG = REG_A0
) (
  input logic   clk,
  input logic   rstn,
  wbu_if.slave  bus
);
  wb_state_e       state, state_nxt;
  logic            fire, wr_en, halt_set, running;
  logic [XLEN-1:0] exit_data;

  assign fire = bus.instr_valid & bus.mmu_valid & (state == WB_RUN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= WB_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == WB_RUN && fire && bus.mmu_ebreak_en) state_nxt = WB_HALT;
  end

  always_comb begin
    running  = 1'b0;
    wr_en    = 1'b0;
    halt_set = 1'b0;
    if (state == WB_RUN) begin
      running  = 1'b1;
      wr_en    = fire & bus.mmu_wb_en;
      halt_set = fire & bus.mmu_ebreak_en;
    end
  end

  regfile #(.XLEN(XLEN), .EXIT_REG(EXIT_REG)) u_rf (
    .clk       (clk),
    .rstn      (rstn),
    .we        (wr_en),
    .waddr     (bus.mmu_index_rd),
    .wdata     (bus.mmu_wb_data),
    .rs1       (bus.idu_index_rs1),
    .rs2       (bus.idu_index_rs2),
    .rd1       (bus.idu_data_rs1),
    .rd2       (bus.idu_data_rs2),
    .exit_data (exit_data)
  );

  // HALT is absorbing, so the halt flag is just the decoded state.
  assign bus.halt = (state == WB_HALT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.wbu_valid  <= 1'b0;
      bus.wbu_pc     <= '0;
      bus.wbu_instr  <= '0;
      bus.halt_code  <= '0;
      bus.cycle_cnt  <= '0;
      bus.retire_cnt <= '0;
    end else begin
      bus.wbu_valid <= fire;
      if (fire) begin
        bus.wbu_pc     <= bus.mmu_pc;
        bus.wbu_instr  <= bus.mmu_instr;
        bus.retire_cnt <= bus.retire_cnt + 1'b1;
      end
      if (halt_set) bus.halt_code <= exit_data;
      if (running)  bus.cycle_cnt <= bus.cycle_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_wbu.sv
// Directed bench for wbu: commit scoreboard plus a small architectural model of regs/counters.
module tb_wbu;
  import wbu_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wbu_if #(.XLEN(64)) bus ();

  wbu #(.XLEN(64), .EXIT_REG(5'd10)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } commit_t;

  commit_t     sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [63:0] m_regs [32];
  logic        m_halt;
  logic [63:0] m_cycle, m_retire, m_code;
  logic [63:0] saved;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_fire();
    return bus.instr_valid & bus.mmu_valid & ~m_halt;
  endfunction

  function automatic logic [63:0] model_rd(input logic [4:0] idx);
    if (idx == 5'd0) return 64'd0;
    if (model_fire() && bus.mmu_wb_en && bus.mmu_index_rd == idx) return bus.mmu_wb_data;
    return m_regs[idx];
  endfunction

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 64'd0;
    m_halt = 1'b0; m_cycle = 64'd0; m_retire = 64'd0; m_code = 64'd0;
    sb.delete();
  endtask

  task automatic drive(input logic iv, input logic mv, input logic we, input logic [4:0] rd,
                       input logic [63:0] data, input logic eb, input logic [63:0] pc,
                       input logic [31:0] instr, input logic [4:0] r1, input logic [4:0] r2);
    commit_t c;
    bus.instr_valid = iv; bus.mmu_valid = mv; bus.mmu_wb_en = we; bus.mmu_index_rd = rd;
    bus.mmu_wb_data = data; bus.mmu_ebreak_en = eb; bus.mmu_pc = pc; bus.mmu_instr = instr;
    bus.idu_index_rs1 = r1; bus.idu_index_rs2 = r2;
    if (model_fire()) begin
      c.pc = pc; c.instr = instr;
      sb.push_back(c);
    end
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 32'd0, r1, r2);
  endtask

  task automatic chk_reads(input string tag);
    #1;
    chk({tag, "_rs1"}, bus.idu_data_rs1, model_rd(bus.idu_index_rs1));
    chk({tag, "_rs2"}, bus.idu_data_rs2, model_rd(bus.idu_index_rs2));
  endtask

  task automatic tick(input string tag);
    logic    f;
    commit_t c;
    @(posedge clk);
    f = model_fire();
    if (!m_halt) m_cycle++;
    if (f) begin
      m_retire++;
      if (bus.mmu_ebreak_en) begin
        m_code = model_rd(5'd10);
        m_halt = 1'b1;
      end
      if (bus.mmu_wb_en && bus.mmu_index_rd != 5'd0) m_regs[bus.mmu_index_rd] = bus.mmu_wb_data;
    end
    #1;
    chk({tag, "_valid"}, 64'(bus.wbu_valid), 64'(f));
    if (f) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $error("FAIL %s_sb observed=commit expected=empty_queue", tag);
      end else begin
        c = sb.pop_front();
        chk({tag, "_pc"}, bus.wbu_pc, c.pc);
        chk({tag, "_instr"}, 64'(bus.wbu_instr), 64'(c.instr));
      end
    end
    chk({tag, "_halt"}, 64'(bus.halt), 64'(m_halt));
    chk({tag, "_code"}, bus.halt_code, m_code);
    chk({tag, "_cycle"}, bus.cycle_cnt, m_cycle);
    chk({tag, "_retire"}, bus.retire_cnt, m_retire);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.wbu_valid), 64'd0);
    chk({tag, "_pc"}, bus.wbu_pc, 64'd0);
    chk({tag, "_instr"}, 64'(bus.wbu_instr), 64'd0);
    chk({tag, "_halt"}, 64'(bus.halt), 64'd0);
    chk({tag, "_code"}, bus.halt_code, 64'd0);
    chk({tag, "_cycle"}, bus.cycle_cnt, 64'd0);
    chk({tag, "_retire"}, bus.retire_cnt, 64'd0);
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    idle(5'd5, 5'd0);
    #12 rstn = 1'b1;
    chk_zero("rst");
    chk_reads("rst");
    tick("rst_idle");

    // Same-cycle bypass on both ports, then the stored value after the edge.
    drive(1'b1, 1'b1, 1'b1, 5'd3, 64'hDEAD_BEEF, 1'b0, 64'h8000_0000, 32'h0010_0093, 5'd3, 5'd3);
    chk_reads("byp");
    chk("byp_const", bus.idu_data_rs1, 64'hDEAD_BEEF);
    tick("wr3");
    idle(5'd3, 5'd0);
    chk_reads("stored");
    chk("stored_const", bus.idu_data_rs1, 64'hDEAD_BEEF);
    tick("idle1");

    drive(1'b1, 1'b1, 1'b1, 5'd0, 64'h1234, 1'b0, 64'h8000_0004, 32'h0000_0013, 5'd0, 5'd3);
    chk_reads("x0");
    tick("wr0");
    chk("x0_retire", bus.retire_cnt, 64'd2);

    drive(1'b1, 1'b1, 1'b1, 5'd7, 64'hCAFE_F00D_0000_0007, 1'b0, 64'h8000_0008, 32'h0070_0393, 5'd7, 5'd7);
    chk_reads("dual");
    tick("wr7");

    // Bubble: mmu_valid low must not write even with wb_en set.
    drive(1'b1, 1'b0, 1'b1, 5'd5, 64'h5555, 1'b0, 64'h8000_000C, 32'h1, 5'd5, 5'd7);
    chk_reads("bubble");
    tick("bubble");
    idle(5'd5, 5'd7);
    chk_reads("bubble_after");

    saved = m_retire;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 5'd6, 64'h6666, 1'b0, 64'h8000_0010, 32'h2, 5'd6, 5'd3);
      chk_reads("freeze");
      tick("freeze");
    end
    chk("freeze_retire", bus.retire_cnt, saved);
    chk("freeze_cycle", bus.cycle_cnt, 64'd9);

    drive(1'b1, 1'b1, 1'b1, 5'd10, 64'h2A, 1'b0, 64'h8000_0014, 32'h02A0_0513, 5'd10, 5'd0);
    chk_reads("wr10");
    tick("wr10");

    drive(1'b1, 1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 64'h8000_0018, 32'h0010_0073, 5'd10, 5'd0);
    tick("ebreak");
    chk("ebreak_halt", 64'(bus.halt), 64'd1);
    chk("ebreak_code", bus.halt_code, 64'h2A);

    // Halted: a would-be write to x4 is ignored and counters freeze.
    saved = m_cycle;
    drive(1'b1, 1'b1, 1'b1, 5'd4, 64'h99, 1'b0, 64'h8000_001C, 32'h3, 5'd4, 5'd10);
    chk_reads("halted_rd");
    tick("halted_fire");
    idle(5'd4, 5'd0);
    chk_reads("halted_x4");
    tick("halted_idle");
    chk("halted_cycle", bus.cycle_cnt, saved);

    // Asynchronous reset between edges while halted.
    idle(5'd3, 5'd10);
    #3 rstn = 1'b0;
    #1 model_reset();
    chk_zero("async_rst");
    chk_reads("async_rst");
    #2 rstn = 1'b1;
    tick("resume");
    chk("resume_cycle", bus.cycle_cnt, 64'd1);

    // Ebreak that also writes a0: halt code comes through the bypass.
    drive(1'b1, 1'b1, 1'b1, 5'd10, 64'h77, 1'b1, 64'h8000_0100, 32'h0010_0073, 5'd10, 5'd0);
    chk_reads("eb_byp");
    tick("eb_byp");
    chk("eb_byp_code", bus.halt_code, 64'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
